// File: rtl/ucsbece152a_bcd_counter_display.sv
// ucsbece152a_bcd_counter_display: DIGITS-wide BCD up/down counter advanced by
// a prescaler tick, with a time-multiplexed active-low seven-segment scan driver.
//
// Ports:
//   clk       - system clock
//   rst       - synchronous active-high reset (highest priority)
//   enable_i  - 1 = counter advances on tick
//   dir_i     - 1 = count up, 0 = count down (sampled in the tick cycle)
//   clear_i   - synchronous clear of count and prescaler
//   count_o   - packed BCD count, digit 0 in [3:0]
//   wrap_o    - one-cycle pulse after a wrap-around update
//   an_o      - one-hot active-low digit enables
//   seg_o     - active-low segments {a,b,c,d,e,f,g}, a = bit 6
module ucsbece152a_bcd_counter_display #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_i,
    input  logic                  dir_i,
    input  logic                  clear_i,
    output logic [4*DIGITS-1:0]   count_o,
    output logic                  wrap_o,
    output logic [DIGITS-1:0]     an_o,
    output logic [6:0]            seg_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);

    logic [PW-1:0]         r_presc;
    logic [SW-1:0]         r_scan;
    logic [IW-1:0]         r_idx;
    logic [4*DIGITS-1:0]   r_count;
    logic                  r_wrap;

    logic                  w_tick;
    logic [4*DIGITS-1:0]   w_count_nx;
    logic                  w_ripple;
    logic [DIGITS-1:0]     w_an;
    logic [3:0]            w_digit;
    logic                  w_blank;
    logic                  w_zero;
    logic [6:0]            w_seg;

    assign w_tick = (r_presc == TICK_MAX);

    // Ripple carry/borrow through all digits in one cycle. A carry left over
    // past the top digit means the whole count wrapped.
    always_comb begin
        w_count_nx = r_count;
        w_ripple   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_ripple) begin
                if (dir_i) begin
                    if (r_count[4*i +: 4] == 4'd9) begin
                        w_count_nx[4*i +: 4] = 4'd0;
                    end else begin
                        w_count_nx[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                        w_ripple = 1'b0;
                    end
                end else begin
                    if (r_count[4*i +: 4] == 4'd0) begin
                        w_count_nx[4*i +: 4] = 4'd9;
                    end else begin
                        w_count_nx[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
                        w_ripple = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_scan  <= '0;
            r_idx   <= '0;
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            if (clear_i || w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PW'(1);
            end

            if (clear_i) begin
                r_count <= '0;
                r_wrap  <= 1'b0;
            end else if (w_tick && enable_i) begin
                r_count <= w_count_nx;
                r_wrap  <= w_ripple;
            end else begin
                r_wrap  <= 1'b0;
            end

            if (r_scan == SCAN_MAX) begin
                r_scan <= '0;
                r_idx  <= (r_idx == IDX_MAX) ? '0 : r_idx + IW'(1);
            end else begin
                r_scan <= r_scan + SW'(1);
            end
        end
    end

    // Walk from the top digit down so w_zero holds "digits i..DIGITS-1 are
    // all zero" when digit i is considered.
    always_comb begin
        w_an    = '1;
        w_digit = 4'd0;
        w_blank = 1'b0;
        w_zero  = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero = w_zero && (r_count[4*i +: 4] == 4'd0);
            if (r_idx == IW'(i)) begin
                w_an[i] = 1'b0;
                w_digit = r_count[4*i +: 4];
                w_blank = (BLANK_LZ != 0) && (i != 0) && w_zero;
            end
        end
    end

    always_comb begin
        case (w_digit)
            4'd0:    w_seg = 7'b0000001;
            4'd1:    w_seg = 7'b1001111;
            4'd2:    w_seg = 7'b0010010;
            4'd3:    w_seg = 7'b0000110;
            4'd4:    w_seg = 7'b1001100;
            4'd5:    w_seg = 7'b0100100;
            4'd6:    w_seg = 7'b0100000;
            4'd7:    w_seg = 7'b0001111;
            4'd8:    w_seg = 7'b0000000;
            4'd9:    w_seg = 7'b0000100;
            default: w_seg = 7'b1111111;
        endcase
    end

    assign count_o = r_count;
    assign wrap_o  = r_wrap;
    assign an_o    = w_an;
    assign seg_o   = w_blank ? 7'b1111111 : w_seg;

endmodule

// File: tb/tb_ucsbece152a_bcd_counter_display.sv
// tb_ucsbece152a_bcd_counter_display: directed bench for the BCD counter and
// scan display (DIGITS=2, SCAN_DIV=2, TICK_DIV=1 plus a TICK_DIV=4 instance).
module tb_ucsbece152a_bcd_counter_display;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable_i;
    logic       dir_i;
    logic       clear_i;
    logic [7:0] count_o;
    logic       wrap_o;
    logic [1:0] an_o;
    logic [6:0] seg_o;
    logic [7:0] count4;
    logic       wrap4;
    logic [1:0] an4;
    logic [6:0] seg4;

    int n_tests = 0;
    int n_fail  = 0;
    int ncyc    = 0;

    always #5 clk = ~clk;

    ucsbece152a_bcd_counter_display #(
        .DIGITS(2), .TICK_DIV(1), .SCAN_DIV(2), .BLANK_LZ(1)
    ) dut (
        .clk(clk), .rst(rst), .enable_i(enable_i), .dir_i(dir_i),
        .clear_i(clear_i), .count_o(count_o), .wrap_o(wrap_o),
        .an_o(an_o), .seg_o(seg_o)
    );

    ucsbece152a_bcd_counter_display #(
        .DIGITS(2), .TICK_DIV(4), .SCAN_DIV(2), .BLANK_LZ(1)
    ) dut4 (
        .clk(clk), .rst(rst), .enable_i(enable_i), .dir_i(dir_i),
        .clear_i(clear_i), .count_o(count4), .wrap_o(wrap4),
        .an_o(an4), .seg_o(seg4)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        ncyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        ncyc = 0;
    endtask

    // Expected digit index: scan state restarts at reset, SCAN_DIV = 2.
    function automatic int exp_idx();
        return (ncyc / 2) % 2;
    endfunction

    task automatic check_scan(input string tag, input logic [6:0] seg0,
                              input logic [6:0] seg1);
        for (int k = 0; k < 8; k++) begin
            if (exp_idx() == 0) begin
                chk({tag, "_an"}, 32'(an_o), 32'b10);
                chk({tag, "_seg0"}, 32'(seg_o), 32'(seg0));
            end else begin
                chk({tag, "_an"}, 32'(an_o), 32'b01);
                chk({tag, "_seg1"}, 32'(seg_o), 32'(seg1));
            end
            step();
        end
    endtask

    initial begin
        rst      = 1'b1;
        enable_i = 1'b0;
        dir_i    = 1'b1;
        clear_i  = 1'b0;

        // Reset
        @(posedge clk);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        ncyc = 0;
        chk("rst_count", 32'(count_o), 32'h00);
        chk("rst_an", 32'(an_o), 32'b10);
        chk("rst_seg", 32'(seg_o), 32'b0000001);
        chk("rst_wrap", 32'(wrap_o), 32'd0);
        step();
        step();
        chk("hold_count", 32'(count_o), 32'h00);
        chk("hold_wrap", 32'(wrap_o), 32'd0);

        // Up-count with decimal carry and wrap
        enable_i = 1'b1;
        dir_i    = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            step();
            chk("up_count", 32'(count_o), 32'(bcd(k % 100)));
            chk("up_wrap", 32'(wrap_o), 32'((k % 100) == 0));
        end

        // Down-count and direction change
        dir_i = 1'b0;
        step();
        chk("dn_count99", 32'(count_o), 32'h99);
        chk("dn_wrap", 32'(wrap_o), 32'd1);
        step();
        chk("dn_count98", 32'(count_o), 32'h98);
        chk("dn_wrap_off", 32'(wrap_o), 32'd0);
        dir_i = 1'b1;
        step();
        chk("tog_count99", 32'(count_o), 32'h99);
        chk("tog_wrap", 32'(wrap_o), 32'd0);

        // Clear versus tick
        do_reset();
        for (int k = 0; k < 42; k++) step();
        chk("pre_clr", 32'(count_o), 32'h42);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        chk("clr_count", 32'(count_o), 32'h00);
        chk("clr_wrap", 32'(wrap_o), 32'd0);
        chk("clr_count4", 32'(count4), 32'h00);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("clr_run", 32'(count_o), 32'(bcd(k)));
            chk("clr_tick4", 32'(count4), (k == 4) ? 32'h01 : 32'h00);
        end

        // Scan and blanking: 07 blanks the upper digit
        do_reset();
        for (int k = 0; k < 7; k++) step();
        enable_i = 1'b0;
        chk("scan07_count", 32'(count_o), 32'h07);
        check_scan("scan07", 7'b0001111, 7'b1111111);

        // 70 shows both digits
        enable_i = 1'b1;
        do_reset();
        for (int k = 0; k < 70; k++) step();
        enable_i = 1'b0;
        chk("scan70_count", 32'(count_o), 32'h70);
        check_scan("scan70", 7'b0000001, 7'b0001111);

        // Mid-operation reset
        enable_i = 1'b1;
        do_reset();
        for (int k = 0; k < 55; k++) step();
        chk("pre_mrst", 32'(count_o), 32'h55);
        chk("pre_mrst_idx", 32'(an_o), 32'b01);
        rst = 1'b1;
        step();
        rst  = 1'b0;
        ncyc = 0;
        chk("mrst_count", 32'(count_o), 32'h00);
        chk("mrst_wrap", 32'(wrap_o), 32'd0);
        chk("mrst_an", 32'(an_o), 32'b10);
        chk("mrst_seg", 32'(seg_o), 32'b0000001);
        chk("mrst_count4", 32'(count4), 32'h00);
        step();
        chk("mrst_restart", 32'(count_o), 32'h01);
        chk("mrst_an1", 32'(an_o), 32'b10);
        step();
        chk("mrst_restart2", 32'(count_o), 32'h02);
        chk("mrst_an2", 32'(an_o), 32'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ucsbece152a_bcd_counter_display.md
Name: ucsbece152a_bcd_counter_display

Overview:
- Parametrised successor to the single-digit 3-bit counter/decoder top.
- Contains a DIGITS-wide BCD up/down counter, advanced by an internal prescaler tick.
- Contains a time-multiplexed seven-segment scan driver that shows all digits on one shared segment bus.
- Adds synchronous clear, a wrap pulse and optional leading-zero blanking.
- Sits directly under the FPGA top and drives board digit-enable and segment pins.

Parameters:
- DIGITS, 4, number of BCD digits displayed and counted (1..8).
- TICK_DIV, 50000000, clk cycles per count tick (>=1; 1 = tick every cycle).
- SCAN_DIV, 50000, clk cycles per digit-scan step (>=1).
- BLANK_LZ, 1, 1 = blank leading zero digits (digit 0 never blanked).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- enable_i, input, 1, 1 = counter advances on tick.
- dir_i, input, 1, 1 = count up, 0 = count down.
- clear_i, input, 1, synchronous clear of count and prescaler.
- count_o, output, 4*DIGITS, packed BCD count; digit 0 in [3:0].
- wrap_o, output, 1, one-cycle pulse on wrap-around.
- an_o, output, DIGITS, digit enables; one-hot, active-low.
- seg_o, output, 7, segments {a,b,c,d,e,f,g}, a = bit 6; active-low.

Behaviour:
- Reset:
  - Synchronous, active-high: rst sampled on rising clk only, with highest priority.
  - Reset values: count = 0, prescaler = 0, scan counter = 0, digit index = 0, wrap_o = 0.
  - Outputs out of reset: an_o = all ones except bit 0 = 0; seg_o = 7'b0000001 (digit "0").
- Prescaler:
  - Free-running counter, 0..TICK_DIV-1.
  - tick is asserted for the one cycle in which the prescaler equals TICK_DIV-1; the prescaler then wraps to 0.
  - Runs regardless of enable_i.
  - clear_i forces the prescaler to 0.
- Counter update, applied at the clock edge of a tick cycle when enable_i = 1 and clear_i = 0:
  - Up: digit 0 increments. A 9 goes to 0 and carries into the next digit; the ripple is resolved within the same cycle.
  - Down: digit 0 decrements. A 0 goes to 9 and borrows from the next digit.
  - Up from all 9s -> all 0s; wrap_o = 1 in the cycle after the edge, for exactly one cycle.
  - Down from all 0s -> all 9s; wrap_o = 1 in the same way.
  - dir_i is sampled in the tick cycle only. Changing dir_i between ticks has no effect.
  - With enable_i = 0 the count holds and wrap_o = 0; the tick is discarded, not deferred.
- clear_i:
  - Takes priority over a tick.
  - Sets count = 0 and prescaler = 0; wrap_o = 0.
  - Does not affect the scan state.
- count_o is registered and changes one clock after the updating edge (latency 1 from the tick cycle).
- Digit values are always in 0..9; no non-BCD code is reachable.
- Scan:
  - The scan counter runs 0..SCAN_DIV-1.
  - When it reaches SCAN_DIV-1, the digit index advances and wraps DIGITS-1 -> 0.
  - The scan is independent of enable_i and clear_i.
- Display outputs:
  - an_o and seg_o are combinational from the registered digit index and registered count, so there is no extra latency.
  - an_o[idx] = 0; all other bits = 1.
- Segment decode, active-low {a..g}:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
- Blanking:
  - When BLANK_LZ = 1 and idx > 0, digit idx is blanked if digits idx..DIGITS-1 are all zero.
  - A blanked digit drives seg_o = 7'b1111111; an_o is unchanged.
- Edge cases:
  - DIGITS = 1 must work: an_o is a constant 0.
  - TICK_DIV = 1 and SCAN_DIV = 1 must work: tick / advance every cycle.

Test Plan (all with DIGITS = 2, TICK_DIV = 1, SCAN_DIV = 2, BLANK_LZ = 1 unless stated):
- Reset:
  - Stimulus: rst = 1 for 2 cycles, then release with enable_i = 0.
  - Required: count_o = 8'h00, an_o = 2'b10, seg_o = 0000001, wrap_o = 0; count holds.
- Up-count carry and wrap:
  - Stimulus: enable_i = 1, dir_i = 1, run 100 cycles.
  - Required: count_o = 8'h09 -> 8'h10 (decimal carry), then 8'h99 -> 8'h00.
  - Required: wrap_o is high for exactly one cycle, coincident with count_o = 8'h00.
- Down-count and direction change:
  - Stimulus: from 8'h00, dir_i = 0.
  - Required: next count_o = 8'h99 with wrap_o pulse, then 8'h98; toggle dir_i = 1 -> 8'h99.
- Clear versus tick:
  - Stimulus: at count 8'h42, assert clear_i together with enable_i = 1.
  - Required: count_o = 8'h00 next cycle, wrap_o = 0.
  - Variant: TICK_DIV = 4; after clear, the first increment occurs exactly 4 cycles later.
- Scan and blanking:
  - Stimulus: count 8'h07.
  - Required: an_o alternates 10, 10, 01, 01 with period 4 cycles.
  - Required: seg_o = 0001111 while an_o = 10; seg_o = 1111111 while an_o = 01.
  - Variant: count 8'h70 shows both digits.
- Mid-operation reset:
  - Stimulus: assert rst at count 8'h55 mid-scan.
  - Required: every register returns to its reset value next cycle, and counting restarts from 8'h00.
